bram_arbiter: RTL and testbench



---
 rtl/bram_arbiter.sv | 156 +++++++++++++++
 tb/tb_bram_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bram_arbiter.sv
// Two-master Wishbone arbiter sharing one BRAM slave: round-robin grant held per
// cyc burst, combinational forwarding once granted, and an ack watchdog.
module bram_arbiter #(
  parameter int adr_width = 32,
  parameter int timeout   = 16,
  parameter int cnt_width = 5
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,

  input  logic                 m0_cyc_i,
  input  logic                 m0_stb_i,
  input  logic                 m0_we_i,
  input  logic [adr_width-1:0] m0_adr_i,
  input  logic [31:0]          m0_dat_i,
  input  logic [3:0]           m0_sel_i,
  output logic [31:0]          m0_dat_o,
  output logic                 m0_ack_o,
  output logic                 m0_err_o,

  input  logic                 m1_cyc_i,
  input  logic                 m1_stb_i,
  input  logic                 m1_we_i,
  input  logic [adr_width-1:0] m1_adr_i,
  input  logic [31:0]          m1_dat_i,
  input  logic [3:0]           m1_sel_i,
  output logic [31:0]          m1_dat_o,
  output logic                 m1_ack_o,
  output logic                 m1_err_o,

  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  output logic                 s_we_o,
  output logic [adr_width-1:0] s_adr_o,
  output logic [31:0]          s_dat_o,
  output logic [3:0]           s_sel_o,
  input  logic [31:0]          s_dat_i,
  input  logic                 s_ack_i,

  output logic [1:0]           grant_o
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  localparam logic [cnt_width-1:0] cnt_last = cnt_width'(timeout > 0 ? timeout - 1 : 0);

  state_t               state, state_next;
  logic                 last, last_next;
  logic [cnt_width-1:0] cnt;
  logic                 errq;
  logic                 wd_active;
  logic                 wd_fire;

  // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_next;
      last  <= last_next;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    last_next  = last;
    case (state)
      IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || last)) begin
          state_next = GNT0;
          last_next  = 1'b0;
        end else if (m1_cyc_i) begin
          state_next = GNT1;
          last_next  = 1'b1;
        end
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          if (m1_cyc_i) begin
            state_next = GNT1;
            last_next  = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          if (m0_cyc_i) begin
            state_next = GNT0;
            last_next  = 1'b0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Slave side decodes purely from state, so reset silences it without a clock edge.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = 4'b0000;
    s_adr_o = m0_adr_i;
    s_dat_o = m0_dat_i;
    case (state)
      GNT0: begin
        s_cyc_o = m0_cyc_i & ~errq;
        s_stb_o = m0_stb_i & ~errq;
        s_we_o  = m0_we_i;
        s_sel_o = m0_sel_i;
      end
      GNT1: begin
        s_cyc_o = m1_cyc_i & ~errq;
        s_stb_o = m1_stb_i & ~errq;
        s_we_o  = m1_we_i;
        s_sel_o = m1_sel_i;
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
      end
      default: ;
    endcase
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = s_ack_i & (state == GNT0);
  assign m1_ack_o = s_ack_i & (state == GNT1);
  assign m0_err_o = errq & (state == GNT0);
  assign m1_err_o = errq & (state == GNT1);
  assign grant_o  = {state == GNT1, state == GNT0};

  // Watchdog: an ack in the final counted cycle takes priority over the error.
  assign wd_active = s_cyc_o & s_stb_o;
  assign wd_fire   = (timeout != 0) && wd_active && !s_ack_i && (cnt == cnt_last);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt  <= '0;
      errq <= 1'b0;
    end else begin
      errq <= wd_fire;
      if (!wd_active || s_ack_i || wd_fire) begin
        cnt <= '0;
      end else if (cnt != '1) begin
        cnt <= cnt + cnt_width'(1);
      end
    end
  end

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a small BRAM slave model (1-cycle ack).
module tb_bram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        m0_cyc, m0_stb, m0_we;
  logic [31:0] m0_adr, m0_wdat, m0_rdat;
  logic [3:0]  m0_sel;
  logic        m0_ack, m0_err;

  logic        m1_cyc, m1_stb, m1_we;
  logic [31:0] m1_adr, m1_wdat, m1_rdat;
  logic [3:0]  m1_sel;
  logic        m1_ack, m1_err;

  logic        s_cyc, s_stb, s_we;
  logic [31:0] s_adr, s_wdat, s_rdat;
  logic [3:0]  s_sel;
  logic        s_ack;
  logic [1:0]  grant;

  logic        bram_en, bram_ack, manual_ack;
  logic [31:0] mem [0:255];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bram_arbiter #(.adr_width(32), .timeout(16), .cnt_width(5)) dut (
    .sys_clk  (clk),
    .sys_rst  (rst),
    .m0_cyc_i (m0_cyc), .m0_stb_i (m0_stb), .m0_we_i (m0_we),
    .m0_adr_i (m0_adr), .m0_dat_i (m0_wdat), .m0_sel_i (m0_sel),
    .m0_dat_o (m0_rdat), .m0_ack_o (m0_ack), .m0_err_o (m0_err),
    .m1_cyc_i (m1_cyc), .m1_stb_i (m1_stb), .m1_we_i (m1_we),
    .m1_adr_i (m1_adr), .m1_dat_i (m1_wdat), .m1_sel_i (m1_sel),
    .m1_dat_o (m1_rdat), .m1_ack_o (m1_ack), .m1_err_o (m1_err),
    .s_cyc_o  (s_cyc), .s_stb_o (s_stb), .s_we_o (s_we),
    .s_adr_o  (s_adr), .s_dat_o (s_wdat), .s_sel_o (s_sel),
    .s_dat_i  (s_rdat), .s_ack_i (s_ack),
    .grant_o  (grant)
  );

  assign s_ack = bram_en ? bram_ack : manual_ack;

  // BRAM slave model: ack one cycle after stb, then low; byte-lane writes.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bram_ack <= 1'b0;
      s_rdat   <= 32'h0;
      mem[64]  <= 32'h1234_5678;
      mem[16]  <= 32'h1122_3344;
    end else if (s_cyc && s_stb && !bram_ack) begin
      bram_ack <= 1'b1;
      s_rdat   <= mem[s_adr[9:2]];
      if (s_we) begin
        for (int b = 0; b < 4; b++) begin
          if (s_sel[b]) mem[s_adr[9:2]][8*b +: 8] <= s_wdat[8*b +: 8];
        end
      end
    end else begin
      bram_ack <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    int n;
    int acks;
    logic seen_err;

    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = 0; m0_wdat = 0; m0_sel = 0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = 0; m1_wdat = 0; m1_sel = 0;
    bram_en = 1'b1; manual_ack = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_s_cyc", 64'(s_cyc), 64'd0);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_m0_ack", 64'(m0_ack), 64'd0);
    rst = 1'b0;
    tick();
    check("idle_grant", 64'(grant), 64'd0);

    // m0 single read from 0x100
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h100;
    #1;
    check("arb_latency_grant", 64'(grant), 64'd0);
    tick();
    check("rd_grant", 64'(grant), 64'b01);
    check("rd_s_cyc", 64'(s_cyc), 64'd1);
    check("rd_s_adr", 64'(s_adr), 64'h100);
    tick();
    check("rd_m0_ack", 64'(m0_ack), 64'd1);
    check("rd_m0_dat", 64'(m0_rdat), 64'h1234_5678);
    check("rd_m1_ack", 64'(m1_ack), 64'd0);
    m0_cyc = 0; m0_stb = 0;
    tick();
    check("rd_release", 64'(grant), 64'd0);

    // Simultaneous requests after reset: m0 first, direct handover, then m0 again
    do_reset();
    m0_cyc = 1; m1_cyc = 1;
    tick();
    check("sim_first_m0", 64'(grant), 64'b01);
    m0_cyc = 0;
    tick();
    check("sim_handover_m1", 64'(grant), 64'b10);
    check("sim_m1_s_cyc", 64'(s_cyc), 64'd1);
    m1_cyc = 0;
    tick();
    check("sim_idle", 64'(grant), 64'd0);
    m0_cyc = 1; m1_cyc = 1;
    tick();
    check("sim_second_m0", 64'(grant), 64'b01);
    m0_cyc = 0; m1_cyc = 0;
    tick();

    // m0 burst of 4 partial writes while m1 waits
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h40; m0_wdat = 32'hDEAD_BEEF; m0_sel = 4'b0011;
    tick();
    m1_cyc = 1; m1_adr = 32'h80;
    #1;
    check("wr_s_sel", 64'(s_sel), 64'b0011);
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!m0_ack && n < 8) begin
        tick();
        n++;
      end
      if (m0_ack) acks++;
      check("wr_hold_grant", 64'(grant), 64'b01);
      if (i == 3) begin
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 0;
      end
      tick();
    end
    check("wr_ack_count", 64'(acks), 64'd4);
    check("wr_m1_after_drop", 64'(grant), 64'b10);
    check("wr_mem_bytes", 64'(mem[16]), 64'h1122_BEEF);
    m1_cyc = 0;
    tick();

    // Watchdog: ack tied low while m1 holds stb
    bram_en = 1'b0;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h200;
    tick();
    check("wd_s_stb_up", 64'(s_stb), 64'd1);
    seen_err = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      seen_err = seen_err | m1_err | m0_err;
    end
    check("wd_no_early_err", 64'(seen_err), 64'd0);
    tick();
    check("wd_m1_err", 64'(m1_err), 64'd1);
    check("wd_s_stb_low", 64'(s_stb), 64'd0);
    check("wd_m0_err", 64'(m0_err), 64'd0);
    check("wd_grant_kept", 64'(grant), 64'b10);
    tick();
    check("wd_err_one_cycle", 64'(m1_err), 64'd0);
    m1_cyc = 0; m1_stb = 0;
    tick();

    // Ack in the last counted cycle beats the watchdog
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h300;
    tick();
    for (int i = 0; i < 15; i++) tick();
    manual_ack = 1'b1;
    #1;
    check("late_ack_delivered", 64'(m0_ack), 64'd1);
    tick();
    manual_ack = 1'b0;
    check("late_ack_no_err", 64'(m0_err), 64'd0);
    tick();
    check("late_ack_no_err2", 64'(m0_err), 64'd0);
    m0_cyc = 0; m0_stb = 0;
    tick();
    bram_en = 1'b1;

    // Asynchronous reset during GNT1
    m1_cyc = 1;
    tick();
    check("mid_grant_m1", 64'(grant), 64'b10);
    #1 rst = 1'b1;
    #1;
    check("async_s_cyc", 64'(s_cyc), 64'd0);
    check("async_grant", 64'(grant), 64'd0);
    m0_cyc = 1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_m0", 64'(grant), 64'b01);
    m0_cyc = 0; m1_cyc = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
